// File: rtl/branch_update_scheduler.sv
// Branch update scheduler: serialises resolved-branch writes and invalidate sweeps into the branching buffer.
// Latency: an event accepted at edge N is presented on upd_* in the following cycle (no combinational bypass).
// Backpressure: full_o while DEPTH events are held; a push while full is dropped. Optional stats via BRANCH_SCHED_STATS_EN.
module branch_update_scheduler #(
    parameter int IDX_W = 10,
    parameter int TGT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             res_valid_e_i,
    input  logic [IDX_W-1:0] pc_e_i,
    input  logic [TGT_W-1:0] pc_target_e_i,
    input  logic             pc_src_res_e_i,
    input  logic             target_match_i,
    input  logic [1:0]       local_src_i,
    input  logic             flush_req_i,
    output logic             upd_valid_o,
    output logic [IDX_W-1:0] upd_idx_o,
    output logic [TGT_W-1:0] upd_target_o,
    output logic             upd_taken_o,
    output logic             upd_match_o,
    output logic [1:0]       upd_local_src_o,
    output logic             inv_valid_o,
    output logic [IDX_W-1:0] inv_idx_o,
    output logic             busy_o,
    output logic             full_o,
    output logic             sweep_done_o
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0]      upd_cnt_o,
    output logic [15:0]      drop_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);

    localparam int SIDX_W = IDX_W + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [SIDX_W-1:0] LAST_IDX = {1'b0, {IDX_W{1'b1}}};
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TGT_W-1:0] tgt;
        logic             taken;
        logic             match;
        logic [1:0]       lsrc;
    } ent_t;

    state_e            state_q, state_d;
    logic [SIDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic              sweep_done_q, sweep_done_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    ent_t              mem_q [DEPTH];
    ent_t              mem_d [DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic sweep_last;
    ent_t head;
    ent_t in_ent;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = res_valid_e_i && !fifo_full;
    assign pop        = (state_q == RUN) && !fifo_empty;
    assign sweep_last = (state_q == SWEEP) && (sweep_idx_q == LAST_IDX);
    assign head       = mem_q[rd_ptr_q];
    assign in_ent     = '{idx: pc_e_i, tgt: pc_target_e_i, taken: pc_src_res_e_i,
                          match: target_match_i, lsrc: local_src_i};

    // State register and control/pointer flops; reset returns to a fresh sweep with an empty FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= SWEEP;
            sweep_idx_q  <= '0;
            sweep_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            sweep_done_q <= sweep_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Event storage needs no reset: only entries covered by count_q are ever read
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // Next state: leave SWEEP after the last index; a flush restarts the sweep from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            SWEEP:   if (sweep_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SWEEP;
        endcase
        if (flush_req_i) begin
            state_d = SWEEP;
        end
    end

    // Sweep index and FIFO bookkeeping; flush empties the FIFO and drops any same-cycle push
    always_comb begin
        sweep_idx_d  = sweep_idx_q;
        sweep_done_d = sweep_last && !flush_req_i;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (state_q == SWEEP) begin
            sweep_idx_d = sweep_last ? '0 : sweep_idx_q + SIDX_W'(1);
        end

        if (flush_req_i) begin
            sweep_idx_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_ent;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Outputs: everything quiet during reset except busy_o; the head entry drives upd_* while popping
    always_comb begin
        upd_valid_o     = !reset_i && pop;
        upd_idx_o       = '0;
        upd_target_o    = '0;
        upd_taken_o     = 1'b0;
        upd_match_o     = 1'b0;
        upd_local_src_o = '0;
        if (upd_valid_o) begin
            upd_idx_o       = head.idx;
            upd_target_o    = head.tgt;
            upd_taken_o     = head.taken;
            upd_match_o     = head.match;
            upd_local_src_o = head.lsrc;
        end
        inv_valid_o  = !reset_i && (state_q == SWEEP);
        inv_idx_o    = inv_valid_o ? sweep_idx_q[IDX_W-1:0] : '0;
        busy_o       = reset_i || (state_q == SWEEP);
        full_o       = !reset_i && fifo_full;
        sweep_done_o = !reset_i && sweep_done_q;
    end

`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Statistics counters clear only on reset; flushes leave them running
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            upd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            upd_cnt_q   <= upd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Increment rules: updates wrap naturally, drop and flush counts saturate
    always_comb begin
        upd_cnt_d   = upd_cnt_q + (upd_valid_o ? 32'd1 : 32'd0);
        drop_cnt_d  = drop_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (res_valid_e_i && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (flush_req_i && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter outputs read zero while reset is held
    always_comb begin
        upd_cnt_o   = reset_i ? '0 : upd_cnt_q;
        drop_cnt_o  = reset_i ? '0 : drop_cnt_q;
        flush_cnt_o = reset_i ? '0 : flush_cnt_q;
    end
`endif

endmodule

// File: tb/tb_branch_update_scheduler.sv
// Bench for branch_update_scheduler: directed stimulus, expected updates queued at push time.
// A negedge monitor pops and compares every presented update; sweep/flush/reset checks are inline.
// Default parameters: 1024-entry buffer, 32-bit target, 4-entry event FIFO.
module tb_branch_update_scheduler;
    localparam int IDX_W = 10;
    localparam int TGT_W = 32;
    localparam int DEPTH = 4;
    localparam int N     = 1 << IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TGT_W-1:0] tgt;
        logic             taken;
        logic             match;
        logic [1:0]       lsrc;
    } ev_t;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             res_valid_e_i = 1'b0;
    logic [IDX_W-1:0] pc_e_i = '0;
    logic [TGT_W-1:0] pc_target_e_i = '0;
    logic             pc_src_res_e_i = 1'b0;
    logic             target_match_i = 1'b0;
    logic [1:0]       local_src_i = '0;
    logic             flush_req_i = 1'b0;
    logic             upd_valid_o;
    logic [IDX_W-1:0] upd_idx_o;
    logic [TGT_W-1:0] upd_target_o;
    logic             upd_taken_o;
    logic             upd_match_o;
    logic [1:0]       upd_local_src_o;
    logic             inv_valid_o;
    logic [IDX_W-1:0] inv_idx_o;
    logic             busy_o;
    logic             full_o;
    logic             sweep_done_o;
`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0]      upd_cnt_o;
    logic [15:0]      drop_cnt_o;
    logic [15:0]      flush_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    branch_update_scheduler #(.IDX_W(IDX_W), .TGT_W(TGT_W), .DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .res_valid_e_i   (res_valid_e_i),
        .pc_e_i          (pc_e_i),
        .pc_target_e_i   (pc_target_e_i),
        .pc_src_res_e_i  (pc_src_res_e_i),
        .target_match_i  (target_match_i),
        .local_src_i     (local_src_i),
        .flush_req_i     (flush_req_i),
        .upd_valid_o     (upd_valid_o),
        .upd_idx_o       (upd_idx_o),
        .upd_target_o    (upd_target_o),
        .upd_taken_o     (upd_taken_o),
        .upd_match_o     (upd_match_o),
        .upd_local_src_o (upd_local_src_o),
        .inv_valid_o     (inv_valid_o),
        .inv_idx_o       (inv_idx_o),
        .busy_o          (busy_o),
        .full_o          (full_o),
        .sweep_done_o    (sweep_done_o)
`ifdef BRANCH_SCHED_STATS_EN
        ,
        .upd_cnt_o       (upd_cnt_o),
        .drop_cnt_o      (drop_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
`endif
    );

    ev_t sbq[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(input int idx, input logic [31:0] tgt, input logic tk,
                                  input logic m, input logic [1:0] ls);
        ev_t e;
        e.idx   = IDX_W'(idx);
        e.tgt   = tgt;
        e.taken = tk;
        e.match = m;
        e.lsrc  = ls;
        return e;
    endfunction

    task automatic set_ev(input ev_t e);
        res_valid_e_i  = 1'b1;
        pc_e_i         = e.idx;
        pc_target_e_i  = e.tgt;
        pc_src_res_e_i = e.taken;
        target_match_i = e.match;
        local_src_i    = e.lsrc;
    endtask

    // Holds one event for exactly one clock edge; queues it when the bench expects acceptance
    task automatic push_ev(input ev_t e, input bit accept);
        set_ev(e);
        @(posedge clk_i);
        #1;
        res_valid_e_i = 1'b0;
        if (accept) sbq.push_back(e);
    endtask

    // Called just after an edge that starts a sweep: checks idx 0..N-1 then the done pulse
    task automatic check_sweep(input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk_i);
            if (inv_valid_o !== 1'b1 || inv_idx_o !== IDX_W'(c) || busy_o !== 1'b1 ||
                upd_valid_o !== 1'b0 || sweep_done_o !== 1'b0)
                bad++;
        end
        chk({name, "_sweep_cycles_bad"}, 64'(bad), 64'd0);
        @(negedge clk_i);
        chk1({name, "_done_pulse"}, sweep_done_o, 1'b1);
        chk1({name, "_busy_after"}, busy_o, 1'b0);
        chk1({name, "_inv_after"}, inv_valid_o, 1'b0);
    endtask

    // Scoreboard monitor: every presented update must match the oldest expected event
    always @(negedge clk_i) begin
        ev_t got;
        ev_t exp_ev;
        if (upd_valid_o === 1'b1) begin
            got = {upd_idx_o, upd_target_o, upd_taken_o, upd_match_o, upd_local_src_o};
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_update: idx %0d issued, no update expected", upd_idx_o);
            end else begin
                exp_ev = sbq.pop_front();
                chk("update_fields", 64'(got), 64'(exp_ev));
            end
        end
    end

    initial begin
        // Reset held for 10 cycles
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk1("reset_busy", busy_o, 1'b1);
        chk1("reset_inv_valid", inv_valid_o, 1'b0);
        chk1("reset_upd_valid", upd_valid_o, 1'b0);
        chk1("reset_full", full_o, 1'b0);
        chk1("reset_sweep_done", sweep_done_o, 1'b0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        // Init sweep with five pushes: four accepted, fifth dropped while full
        fork
            check_sweep("init");
            begin
                for (int i = 1; i <= 4; i++)
                    push_ev(mk_ev(i, 32'h1000 + 32'(i * 4), i[0], ~i[0], 2'(i)), 1'b1);
                @(negedge clk_i);
                chk1("full_after_4", full_o, 1'b1);
                push_ev(mk_ev(5, 32'h1014, 1'b1, 1'b0, 2'd1), 1'b0);
                @(negedge clk_i);
                chk1("full_hold_after_drop", full_o, 1'b1);
            end
        join
        chk1("drain_cycle0", upd_valid_o, 1'b1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_i);
            chk1("drain_consecutive", upd_valid_o, 1'b1);
            chk1("drain_not_full", full_o, 1'b0);
        end
        @(negedge clk_i);
        chk1("drain_done", upd_valid_o, 1'b0);
        chk1("run_no_done_pulse", sweep_done_o, 1'b0);
`ifdef BRANCH_SCHED_STATS_EN
        chk("drop_cnt_one", 64'(drop_cnt_o), 64'd1);
`endif

        // Single event in RUN: visible exactly one cycle after its push edge
        @(posedge clk_i);
        #1;
        set_ev(mk_ev(5, 32'h100, 1'b1, 1'b0, 2'd2));
        @(negedge clk_i);
        chk1("no_bypass", upd_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        res_valid_e_i = 1'b0;
        sbq.push_back(mk_ev(5, 32'h100, 1'b1, 1'b0, 2'd2));
        @(negedge clk_i);
        chk1("latency_one", upd_valid_o, 1'b1);
        chk("latency_idx", 64'(upd_idx_o), 64'd5);
        chk("latency_target", 64'(upd_target_o), 64'h100);
        @(negedge clk_i);
        chk1("single_issue", upd_valid_o, 1'b0);

        // Back-to-back pushes: second push coincides with the first pop
        @(posedge clk_i);
        #1;
        push_ev(mk_ev(12, 32'hABCD0000, 1'b0, 1'b1, 2'd3), 1'b1);
        push_ev(mk_ev(13, 32'h0000_0044, 1'b1, 1'b1, 2'd0), 1'b1);
        @(negedge clk_i);
        chk1("pushpop_second", upd_valid_o, 1'b1);
        chk("pushpop_idx", 64'(upd_idx_o), 64'd13);
        @(negedge clk_i);
        chk1("pushpop_empty", upd_valid_o, 1'b0);

        // Flush from RUN, queue three during the sweep, then flush with a push in the first RUN cycle
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b0;
        sbq.delete();
        fork
            check_sweep("flush1");
            begin
                for (int i = 6; i <= 8; i++)
                    push_ev(mk_ev(i, 32'h2000 + 32'(i), 1'b1, 1'b0, 2'd1), 1'b1);
            end
        join
        chk("flush1_head_shown", 64'(upd_idx_o), 64'd6);
        flush_req_i = 1'b1;
        set_ev(mk_ev(9, 32'h9999, 1'b1, 1'b1, 2'd3));
        @(posedge clk_i);
        #1;
        flush_req_i   = 1'b0;
        res_valid_e_i = 1'b0;
        sbq.delete();
        @(negedge clk_i);
        chk1("flush_fifo_empty_full", full_o, 1'b0);
        chk("flush_restart_idx", 64'(inv_idx_o), 64'd0);
        // first sweep cycle already consumed above; remaining N-1 cycles plus done
        for (int c = 1; c < N; c++) @(negedge clk_i);
        @(negedge clk_i);
        chk1("flush2_done_pulse", sweep_done_o, 1'b1);
        chk1("flush_discarded_push", upd_valid_o, 1'b0);

        // Flush at sweep index 500 restarts from 0 and needs a full 1024 cycles more
        flush_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b0;
        repeat (501) @(negedge clk_i);
        chk("idx_at_500", 64'(inv_idx_o), 64'd500);
        flush_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b0;
        check_sweep("flush_mid");
`ifdef BRANCH_SCHED_STATS_EN
        chk("flush_cnt_four", 64'(flush_cnt_o), 64'd4);
        chk("upd_cnt_eight", 64'(upd_cnt_o), 64'd8);
`endif

        // Reset at sweep index 300 with two queued events: nothing is issued afterwards
        flush_req_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_req_i = 1'b0;
        push_ev(mk_ev(20, 32'h20, 1'b1, 1'b0, 2'd0), 1'b1);
        push_ev(mk_ev(21, 32'h21, 1'b0, 1'b0, 2'd1), 1'b1);
        repeat (299) @(negedge clk_i);
        chk("idx_at_300", 64'(inv_idx_o), 64'd300);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        sbq.delete();
        @(negedge clk_i);
        chk1("midreset_busy", busy_o, 1'b1);
        chk1("midreset_inv_valid", inv_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check_sweep("after_reset");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk1("no_replay_after_reset", upd_valid_o, 1'b0);
        end
`ifdef BRANCH_SCHED_STATS_EN
        chk("drop_cnt_cleared", 64'(drop_cnt_o), 64'd0);
`endif

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
- Sequences all writes into the branching buffer (BTB plus local predictors).
- Queues resolved-branch events from the Execute stage in a small FIFO and issues at most one update per cycle.
- Runs an invalidate sweep over every buffer index after reset, and again on a flush request (e.g. fence.i or a context switch).
- Sits between the Execute-stage resolution logic and the buffer's write port; update and invalidate writes never overlap.

Parameters:
- IDX_W, 10, buffer index width (entries = 2^IDX_W)
- TGT_W, 32, target address width
- DEPTH, 4, event FIFO depth (power of 2, >=2)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- res_valid_e_i  in  1  resolved branch/jump event present this cycle
- pc_e_i  in  IDX_W  buffer index of the resolved instruction
- pc_target_e_i  in  TGT_W  resolved target
- pc_src_res_e_i  in  1  resolved taken
- target_match_i  in  1  stored target matched the resolved target
- local_src_i  in  2  local predictor select
- flush_req_i  in  1  request a full invalidate sweep
- upd_valid_o  out  1  update write strobe
- upd_idx_o  out  IDX_W  update index
- upd_target_o  out  TGT_W  update target
- upd_taken_o  out  1  update outcome
- upd_match_o  out  1  update target-match flag
- upd_local_src_o  out  2  update local select
- inv_valid_o  out  1  invalidate write strobe
- inv_idx_o  out  IDX_W  invalidate index
- busy_o  out  1  sweep in progress
- full_o  out  1  FIFO full; producer must hold off
- sweep_done_o  out  1  one-cycle pulse when a sweep completes

Behaviour:
- FSM states: SWEEP, RUN. There are no other states.
- Reset (reset_i=1 at an edge): state=SWEEP, sweep index=0, FIFO count=0.
  - While reset_i=1, all outputs are 0 except busy_o=1.
- SWEEP:
  - inv_valid_o=1 and inv_idx_o=sweep index; the index increments every cycle.
  - The first cycle after reset deasserts shows idx 0. Idx 2^IDX_W-1 is shown in cycle 2^IDX_W.
  - Following the last index: state=RUN, and sweep_done_o=1 for that first RUN cycle.
  - upd_valid_o=0 throughout SWEEP.
- RUN:
  - inv_valid_o=0 and busy_o=0.
  - If the FIFO is non-empty: upd_valid_o=1, upd_* = head entry, and the head is popped at the clock edge.
- Push rules:
  - res_valid_e_i=1 with FIFO not full: the event is written at the edge.
  - Latency from an empty FIFO in RUN: an event pushed at edge N appears on upd_* in the cycle following edge N (1 cycle). There is no combinational bypass.
  - Pushes are accepted in both states. During SWEEP, events accumulate until RUN.
- Simultaneous push and pop: the count is unchanged and ordering is FIFO.
- full_o = (count==DEPTH), combinational from the count.
  - A push while full is dropped; the FIFO is unchanged.
- Flush:
  - flush_req_i=1 at an edge, in any state: FIFO cleared (count=0), state=SWEEP, index=0.
  - A push in that same cycle is discarded (flush wins).
  - Any in-progress sweep restarts from 0.
  - An update already on upd_* in that cycle is still presented that cycle; it is not replayed.
- Index arithmetic: the sweep index is IDX_W+1 bits. Terminal count is detected at 2^IDX_W-1, so there is no wrap.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.

Optional Feature:
- Macro: BRANCH_SCHED_STATS_EN.
- When defined, three extra outputs are added:
  - upd_cnt_o: 32 bits, counts cycles with upd_valid_o=1.
  - drop_cnt_o: 16 bits, counts pushes dropped while full; saturates at 0xFFFF.
  - flush_cnt_o: 16 bits, counts accepted flush_req_i; saturates at 0xFFFF.
- All three counters clear on reset only; a flush does not clear them.
- When the macro is not defined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset 10 cycles, release -> inv_idx_o steps 0..1023 over 1024 cycles with busy_o=1; sweep_done_o=1 exactly once, in cycle 1025; no upd_valid_o during the sweep.
- In RUN, push one event {pc_e=5, target=0x100, taken=1, match=0, local_src=2} -> the following cycle upd_valid_o=1 with the same fields; the cycle after, upd_valid_o=0.
- During the init sweep, push 5 events (idx 1..5) -> full_o=1 after the 4th; the 5th is dropped; in RUN, upd_idx_o shows 1,2,3,4 on consecutive cycles; drop_cnt_o=1 when the stats macro is enabled.
- Fill 3 events during the sweep, then assert flush_req_i together with a push of idx 9 in RUN -> the FIFO is empty and a new sweep starts from inv_idx_o=0; idx 9 never appears on upd_*.
- Assert flush_req_i when inv_idx_o=500 -> the next cycle shows inv_idx_o=0; completion takes a further 1024 cycles.
- Assert reset_i mid-sweep at idx 300 with 2 events queued -> after release the sweep restarts at 0 and no queued events are issued.
